// File: rtl/l2_data_array_pkg.sv
// ============================================================================
//  Module      : l2_data_array_pkg
//  Description : Shared defaults and FSM state encoding for the L2 data array
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_data_array_pkg;

  // Default array geometry
  localparam int C_DEF_WAYS    = 4;
  localparam int C_DEF_INDEX_W = 9;
  localparam int C_DEF_LINE_W  = 512;
  localparam int C_DEF_BANK_W  = 256;

  // Controller states: post-reset zeroing sweep, then normal service
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

endpackage : l2_data_array_pkg

`default_nettype wire

// File: rtl/l2_data_array_if.sv
// ============================================================================
//  Module      : l2_data_array_if
//  Description : Request / read-return bus of the L2 data array
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l2_data_array_if
  import l2_data_array_pkg::*;
#(
  parameter int WAYS    = C_DEF_WAYS,
  parameter int INDEX_W = C_DEF_INDEX_W,
  parameter int LINE_W  = C_DEF_LINE_W,
  parameter int BANK_W  = C_DEF_BANK_W
) ();

  localparam int NBANK = LINE_W / BANK_W;

  logic                   req;
  logic                   we;
  logic [WAYS-1:0]        way_sel;
  logic [INDEX_W-1:0]     index;
  logic [NBANK-1:0]       wmask;
  logic [LINE_W-1:0]      wd;
  logic                   ready;
  logic                   rd_valid;
  logic [WAYS*LINE_W-1:0] rd;
  logic                   init_done;

  // Requester side
  modport master (
    output req, we, way_sel, index, wmask, wd,
    input  ready, rd_valid, rd, init_done
  );

  // Array side
  modport slave (
    input  req, we, way_sel, index, wmask, wd,
    output ready, rd_valid, rd, init_done
  );

endinterface : l2_data_array_if

`default_nettype wire

// File: rtl/l2_data_array_sram_bank.sv
// ============================================================================
//  Module      : l2_sram_bank
//  Description : Single-port BANK_W x 2^INDEX_W SRAM bank, 1-cycle read.
//                Read data register only updates on a read, so it holds the
//                last read value across writes. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_sram_bank #(
  parameter int BANK_W  = 256,
  parameter int INDEX_W = 9
) (
  input  wire logic               clk,
  input  wire logic               i_we,
  input  wire logic               i_re,
  input  wire logic [INDEX_W-1:0] i_addr,
  input  wire logic [BANK_W-1:0]  i_wdata,
  output logic      [BANK_W-1:0]  o_rdata
);

  localparam int C_DEPTH = 1 << INDEX_W;

  logic [BANK_W-1:0] mem [C_DEPTH];
  logic [BANK_W-1:0] rdata_q;

  // Storage write and registered read; one operation per cycle
  always_ff @(posedge clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) rdata_q     <= mem[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule : l2_sram_bank

`default_nettype wire

// File: rtl/l2_data_array.sv
// ============================================================================
//  Module      : l2_data_array
//  Description : WAYS-way L2 data array built from BANK_W-wide SRAM banks.
//                After reset a sweep zeroes every set, then the array
//                accepts one read or masked write per cycle. Reads return
//                all ways one cycle later; rd holds the last read result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_data_array
  import l2_data_array_pkg::*;
#(
  parameter int WAYS    = C_DEF_WAYS,
  parameter int INDEX_W = C_DEF_INDEX_W,
  parameter int LINE_W  = C_DEF_LINE_W,
  parameter int BANK_W  = C_DEF_BANK_W
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  l2_data_array_if.slave  bus
);

  // LINE_W must be an integer multiple of BANK_W
  localparam int                 NBANK   = LINE_W / BANK_W;
  localparam int                 C_DEPTH = 1 << INDEX_W;
  // Counter is one bit wider than the index so terminal count never wraps
  localparam logic [INDEX_W:0]   C_LAST  = (INDEX_W+1)'(C_DEPTH - 1);

  state_t                 state_q, state_d;
  logic [INDEX_W:0]       cnt_q, cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [WAYS*LINE_W-1:0] hold_q, hold_d;

  logic                   w_init;
  logic                   w_idle;
  logic                   w_accept;
  logic                   w_rd_en;
  logic [INDEX_W-1:0]     w_addr;
  logic [LINE_W-1:0]      w_wdata;
  logic [WAYS*LINE_W-1:0] w_bank_rd;

  assign w_init   = (state_q == ST_INIT);
  assign w_idle   = (state_q == ST_IDLE);
  // Requests are only taken in IDLE; anything during the sweep is dropped
  assign w_accept = bus.req & w_idle;
  assign w_rd_en  = w_accept & ~bus.we;
  // The sweep owns the address and forces zero data while it runs
  assign w_addr   = w_init ? cnt_q[INDEX_W-1:0] : bus.index;
  assign w_wdata  = w_init ? '0 : bus.wd;

  // Next-state, sweep counter, read-valid and hold register
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = w_rd_en;
    hold_d     = rd_valid_q ? w_bank_rd : hold_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.ready     = w_idle;
  assign bus.init_done = w_idle;
  assign bus.rd_valid  = rd_valid_q;
  // Fresh bank data in the valid cycle, captured copy afterwards
  assign bus.rd        = rd_valid_q ? w_bank_rd : hold_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic w_we;
      // Sweep writes every bank; normal writes need both way and bank enable
      assign w_we = w_init | (w_accept & bus.we & bus.way_sel[w] & bus.wmask[b]);

      l2_sram_bank #(
        .BANK_W  (BANK_W),
        .INDEX_W (INDEX_W)
      ) u_bank (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_rd_en),
        .i_addr  (w_addr),
        .i_wdata (w_wdata[b*BANK_W +: BANK_W]),
        .o_rdata (w_bank_rd[(w*NBANK+b)*BANK_W +: BANK_W])
      );
    end
  end

endmodule : l2_data_array

`default_nettype wire

// File: tb/tb_l2_data_array.sv
// ============================================================================
//  Module      : tb_l2_data_array
//  Description : Scoreboard bench for l2_data_array (default geometry)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_data_array;

  localparam int WAYS    = 4;
  localparam int INDEX_W = 9;
  localparam int LINE_W  = 512;
  localparam int BANK_W  = 256;
  localparam int NBANK   = LINE_W / BANK_W;
  localparam int DEPTH   = 1 << INDEX_W;

  typedef logic [WAYS*LINE_W-1:0] rd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_data_array_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .LINE_W(LINE_W), .BANK_W(BANK_W)) bus ();

  l2_data_array #(.WAYS(WAYS), .INDEX_W(INDEX_W), .LINE_W(LINE_W), .BANK_W(BANK_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int  checks   = 0;
  int  failures = 0;
  int  n_reads  = 0;
  int  n_rdv    = 0;
  rd_t exp_q[$];
  rd_t mon_e;
  rd_t last_rd;
  logic [LINE_W-1:0] model [WAYS][DEPTH];

  task automatic check_val(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int i = 0; i < DEPTH; i++)
        model[w][i] = '0;
  endtask

  // Drive one accepted access; writes update the model, reads push expectations
  task automatic op(input logic w, input logic [WAYS-1:0] ws, input int idx,
                    input logic [NBANK-1:0] m, input logic [LINE_W-1:0] d);
    rd_t e;
    @(negedge clk);
    bus.req     = 1'b1;
    bus.we      = w;
    bus.way_sel = ws;
    bus.index   = idx[INDEX_W-1:0];
    bus.wmask   = m;
    bus.wd      = d;
    if (w) begin
      for (int wy = 0; wy < WAYS; wy++)
        for (int b = 0; b < NBANK; b++)
          if (ws[wy] && m[b]) model[wy][idx][b*BANK_W +: BANK_W] = d[b*BANK_W +: BANK_W];
    end else begin
      for (int wy = 0; wy < WAYS; wy++) e[wy*LINE_W +: LINE_W] = model[wy][idx];
      exp_q.push_back(e);
      n_reads++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count cycles until ready; optionally inject an illegal write during the sweep
  task automatic wait_init(input bit inject, output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (inject && n == 100) begin
        bus.req = 1'b1; bus.we = 1'b1; bus.way_sel = '1;
        bus.index = INDEX_W'(3); bus.wmask = '1; bus.wd = '1;
      end
      if (inject && n == 101) bus.req = 1'b0;
    end
  endtask

  // Scoreboard: compare every read return against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      n_rdv++;
      if (exp_q.size() == 0) begin
        check_val("rdv_unexpected", 1, 0);
      end else begin
        mon_e   = exp_q.pop_front();
        last_rd = mon_e;
        for (int w = 0; w < WAYS; w++)
          check_val($sformatf("rd_way%0d", w), bus.rd[w*LINE_W +: LINE_W],
                    mon_e[w*LINE_W +: LINE_W]);
      end
    end
  end

  initial begin
    int n;
    logic [LINE_W-1:0] d;
    bus.req = 1'b0; bus.we = 1'b0; bus.way_sel = '0;
    bus.index = '0; bus.wmask = '0; bus.wd = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", bus.ready, 0);
    check_val("rst_init_done", bus.init_done, 0);
    check_val("rst_rd_valid", bus.rd_valid, 0);
    check_val("rst_rd_lo", bus.rd[LINE_W-1:0], 0);

    // Reset in the middle of the sweep restarts it from scratch
    @(negedge clk) rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check_val("mid_init_ready", bus.ready, 0);
    rst_n = 1'b0;
    #1;
    check_val("rst_again_ready", bus.ready, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_init(1'b1, n);
    check_val("init_len", n, DEPTH);
    check_val("init_done", bus.init_done, 1);
    model_clear();

    // Sweep zeroed the top set; the write dropped during the sweep left no trace
    op(1'b0, '0, 'h1FF, '0, '0);
    op(1'b0, '0, 'h003, '0, '0);
    // Partial-bank write to way2 then read back
    op(1'b1, 4'b0100, 'h005, 2'b01, {64{8'hA5}});
    op(1'b0, '0, 'h005, '0, '0);
    // Full write to way0 immediately followed by a read of the same set
    op(1'b1, 4'b0001, 'h010, 2'b11, {32{16'h1234}});
    op(1'b0, '0, 'h010, '0, '0);
    idle(3);

    // Read, then overwrite the same set: rd keeps the read result
    op(1'b0, '0, 'h005, '0, '0);
    op(1'b1, 4'b0100, 'h005, 2'b11, '1);
    idle(4);
    check_val("hold_rd_valid", bus.rd_valid, 0);
    check_val("rdv_count", n_rdv, n_reads);
    for (int w = 0; w < WAYS; w++)
      check_val($sformatf("hold_way%0d", w), bus.rd[w*LINE_W +: LINE_W],
                last_rd[w*LINE_W +: LINE_W]);

    // Back-to-back mixed traffic over a small set range
    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < LINE_W/32; j++) d[j*32 +: 32] = $urandom;
      op(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 7),
         2'($urandom), d);
    end
    idle(3);

    // Reset right after a read is accepted: no valid pulse, hold cleared
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.index = INDEX_W'(5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check_val("abort_rd_valid", bus.rd_valid, 0);
    check_val("abort_rd_way2", bus.rd[2*LINE_W +: LINE_W], 0);
    check_val("abort_ready", bus.ready, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_init(1'b0, n);
    check_val("init_len2", n, DEPTH);
    model_clear();
    op(1'b0, '0, 'h005, '0, '0);
    op(1'b0, '0, 'h010, '0, '0);
    idle(3);

    check_val("rdv_total", n_rdv, n_reads);
    check_val("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_l2_data_array

`default_nettype wire
